// File: rtl/quickhull_pkg.sv
// Shared definitions for the quickhull result streamer.
//   PTSIZE / NPTS : point width and number of slots in the packed hull bus
//   SIZE_W        : width of the set-size and slot-index fields
//   point_t       : one hull point, X in the low byte, Y in the high byte
//   state_t       : streamer FSM encoding
package quickhull_pkg;
    localparam int PTSIZE = 16;
    localparam int NPTS   = 256;
    localparam int SIZE_W = 8;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
    } point_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;
endpackage

// File: rtl/quickhull_hull_streamer_if.sv
// Bundle of the streamer's capture and readout handshakes.
//   capture side : hull_valid / hull_ready, convexPoints, convexSetSize
//   stream side  : pt_valid / pt_ready, pt_data, pt_index, pt_last
//   control      : flush (abort), busy, done
// slave  = the streamer itself, master = the environment driving it.
interface quickhull_hull_streamer_if;
    import quickhull_pkg::*;

    logic                     hull_valid;
    logic                     hull_ready;
    logic [NPTS*PTSIZE-1:0]   convexPoints;
    logic [SIZE_W-1:0]        convexSetSize;
    logic                     pt_valid;
    logic                     pt_ready;
    point_t                   pt_data;
    logic [SIZE_W-1:0]        pt_index;
    logic                     pt_last;
    logic                     flush;
    logic                     busy;
    logic                     done;

    modport slave (
        input  hull_valid, convexPoints, convexSetSize, pt_ready, flush,
        output hull_ready, pt_valid, pt_data, pt_index, pt_last, busy, done
    );

    modport master (
        output hull_valid, convexPoints, convexSetSize, pt_ready, flush,
        input  hull_ready, pt_valid, pt_data, pt_index, pt_last, busy, done
    );
endinterface

// File: rtl/quickhull_point_mux.sv
// Pure combinational 256:1 selector of one 16-bit point out of the packed
// capture register.
//   points : packed hull, slot k at bits [16k+15:16k]
//   sel    : slot index
//   pt     : selected point
module quickhull_point_mux
    import quickhull_pkg::*;
(
    input  logic [NPTS*PTSIZE-1:0] points,
    input  logic [SIZE_W-1:0]      sel,
    output point_t                 pt
);
    point_t slots [NPTS];

    for (genvar gi = 0; gi < NPTS; gi++) begin : g_slot
        assign slots[gi] = points[gi*PTSIZE +: PTSIZE];
    end

    // sel is 8 bits and NPTS is 256, so every index is in range.
    assign pt = slots[sel];
endmodule

// File: rtl/quickhull_hull_streamer.sv
// Captures a packed convex hull (point bus + set size) in one handshake and
// replays the points one per beat over a valid/ready stream.
//   CLK100MHZ  : system clock, rising edge
//   CPU_RESETN : asynchronous active-low reset
//   bus        : capture handshake, point stream, flush/busy/done
module quickhull_hull_streamer
    import quickhull_pkg::*;
(
    input  logic                      CLK100MHZ,
    input  logic                      CPU_RESETN,
    quickhull_hull_streamer_if.slave  bus
);
    state_t                 state_reg, state_next;
    logic [NPTS*PTSIZE-1:0] capture_reg;
    logic [SIZE_W-1:0]      size_reg;
    logic [SIZE_W-1:0]      idx_reg;
    point_t                 mux_pt;
    logic                   accept;
    logic                   beat;
    logic                   is_last;

    assign accept  = (state_reg == ST_IDLE) && bus.hull_valid;
    // flush wins over a simultaneous transfer: the beat is dropped.
    assign beat    = (state_reg == ST_STREAM) && bus.pt_ready && !bus.flush;
    // Only meaningful in STREAM, where size_reg is at least 1.
    assign is_last = (idx_reg == size_reg - SIZE_W'(1));

    quickhull_point_mux u_point_mux (
        .points (capture_reg),
        .sel    (idx_reg),
        .pt     (mux_pt)
    );

    // State register
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (bus.convexSetSize == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (bus.flush) begin
                    state_next = ST_IDLE;
                end else if (beat && is_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture register and beat counter. The bus is only sampled on accept,
    // so later changes on convexPoints/convexSetSize do not disturb a stream.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            capture_reg <= '0;
            size_reg    <= '0;
            idx_reg     <= '0;
        end else if (accept) begin
            capture_reg <= bus.convexPoints;
            size_reg    <= bus.convexSetSize;
            idx_reg     <= '0;
        end else if (beat && !is_last) begin
            idx_reg     <= idx_reg + SIZE_W'(1);
        end
    end

    // Outputs: decoded from registered state only, so pt_ready never reaches
    // pt_valid combinationally. pt_* are zeroed outside STREAM.
    always_comb begin
        bus.hull_ready = 1'b0;
        bus.pt_valid   = 1'b0;
        bus.pt_data    = '0;
        bus.pt_index   = '0;
        bus.pt_last    = 1'b0;
        bus.done       = 1'b0;
        bus.busy       = (state_reg != ST_IDLE);
        case (state_reg)
            ST_IDLE:   bus.hull_ready = 1'b1;
            ST_STREAM: begin
                bus.pt_valid = 1'b1;
                bus.pt_data  = mux_pt;
                bus.pt_index = idx_reg;
                bus.pt_last  = is_last;
            end
            ST_DONE:   bus.done = 1'b1;
            default:   bus.hull_ready = 1'b0;
        endcase
    end
endmodule

// File: doc/quickhull_hull_streamer.md
# quickhull_hull_streamer

Consumer-side companion to the quickhull processor. Captures the packed convex hull result (point bus plus set size) in one handshake, then streams the hull points out one per beat over a valid/ready interface for downstream display/export logic. Sits between the processor's result registers and any serial consumer, decoupling hull computation from readout rate.

## Interface
- `PTSIZE`, 16, bits per point; X = low byte, Y = high byte.
- `NPTS`, 256, point slots in the packed bus.
- `CLK100MHZ`  input  1  system clock, all logic on rising edge.
- `CPU_RESETN`  input  1  reset, asynchronous, active-low.
- `hull_valid`  input  1  result bus and size are valid this cycle.
- `hull_ready`  output  1  streamer idle and able to capture.
- `convexPoints`  input  NPTS*PTSIZE  packed hull; point k at bits [16k+15:16k].
- `convexSetSize`  input  8  number of valid points (0..255).
- `pt_valid`  output  1  `pt_data` holds a hull point.
- `pt_ready`  input  1  downstream accepts the point.
- `pt_data`  output  PTSIZE  current point.
- `pt_index`  output  8  slot index of current point.
- `pt_last`  output  1  current point is the final one.
- `flush`  input  1  synchronous abort of an active stream.
- `busy`  output  1  capture held, stream not finished.
- `done`  output  1  one-cycle pulse after final point accepted or after empty set.

## Operation
- States: IDLE, STREAM, DONE.
- IDLE: `hull_ready`=1. On `hull_valid && hull_ready`: latch full bus into internal capture register and size into `size_q`; index counter := 0. If size 0 -> DONE; else -> STREAM.
- STREAM: `pt_valid`=1, `pt_data` = capture[16*idx +: 16], `pt_index`=idx, `pt_last` = (idx == size_q-1). Beat transfers when `pt_valid && pt_ready`. On transfer: if `pt_last` -> DONE, else idx+1.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- Output stability: while `pt_valid && !pt_ready`, `pt_data`, `pt_index`, `pt_last` hold constant.
- Changes on `convexPoints`/`convexSetSize` after capture are ignored until return to IDLE.
- `hull_valid` while not IDLE is ignored (no queueing); source must hold until `hull_ready`.
- `flush` in STREAM: -> IDLE next cycle, no `done` pulse, pending beat dropped even if `pt_ready` same cycle. `flush` in IDLE/DONE: no effect. `flush` has priority over transfer.
- `busy` = (state != IDLE).
- Index is 8 bits; size ≤255 guarantees no wrap.

## Timing
- Reset values: `hull_ready`=1, `pt_valid`=0, `pt_data`=0, `pt_index`=0, `pt_last`=0, `busy`=0, `done`=0; capture register and `size_q` cleared; state IDLE.
- Reset asserted mid-stream: all outputs return to reset values immediately (asynchronous); no `done`.
- Capture at edge T -> first `pt_valid` visible after edge T (cycle T+1); `hull_ready` low from T+1.
- With `pt_ready` held high: one point per cycle, N points occupy cycles T+1..T+N; `done` at T+N+1; `hull_ready` high at T+N+2.
- Empty set: `done` at T+1, no `pt_valid`, `hull_ready` high at T+2.
- `pt_*` outputs registered or derived purely from registered state; no combinational path from `pt_ready` to `pt_valid`.

## Structure
- Shared package `quickhull_pkg`: `PTSIZE`, `NPTS`, point typedef (x/y byte fields), set-size width, state encoding constants.
- One sub-module natural: `quickhull_point_mux` — selects point idx from the packed capture register (pure 256:1 16-bit mux).
- Top holds FSM, capture register, counters.

## Test plan
- Size 3, points {0x0102, 0x0304, 0x0506}, `pt_ready`=1 -> beats 0x0102/idx0, 0x0304/idx1, 0x0506/idx2 with `pt_last` only on idx2; `done` one cycle later.
- Size 0 capture -> no `pt_valid`, `done` pulse at T+1, `hull_ready` back at T+2.
- Size 4, `pt_ready` toggled 1,0,0,1,... -> `pt_data` stable during stalls, all 4 points delivered in order exactly once.
- Size 255 with slot k = k*0x0101 -> 255 beats, last beat idx 254 data 0xFEFE with `pt_last`, no index wrap.
- Assert `flush` at beat 2 of size 10 -> `pt_valid` low next cycle, no `done`, `hull_ready` high; new capture of size 1 then streams normally.
- `CPU_RESETN` low mid-stream and change of `convexPoints` mid-stream (no reset) -> reset clears outputs immediately; without reset, streamed data equals captured values, not new bus.
